// File: rtl/freq_meas_ctrl_pkg.sv
// Shared widths, FSM state encoding and channel-pick helper for the
// frequency-measurement sequencer.
package freq_meas_ctrl_pkg;

  localparam int unsigned N_W    = 16;
  localparam int unsigned TICK_W = 32;
  localparam int unsigned NUM_CH = 2;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArm  = 3'd1,
    StWait = 3'd2,
    StAdj  = 3'd3,
    StOut  = 3'd4
  } state_e;

  // Round-robin pick: the pointed-to channel if enabled, otherwise the other one.
  function automatic logic pick_ch(input logic rr, input logic [NUM_CH-1:0] mask);
    return mask[rr] ? rr : ~rr;
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_autorange.sv
// Combinational next edge-count for one channel, from the last gate's outcome.
module freq_meas_ctrl_autorange
  import freq_meas_ctrl_pkg::*;
#(
  parameter int unsigned N_MIN          = 1,
  parameter int unsigned N_MAX          = 50_000,
  parameter int unsigned GATE_MIN_TICKS = 20_000_000
) (
  input  logic [N_W-1:0]    n_cur,
  input  logic [TICK_W-1:0] ticks,
  input  logic              timeout,
  output logic [N_W-1:0]    n_next
);

  localparam logic [N_W:0]      NMaxW = (N_W + 1)'(N_MAX);
  localparam logic [N_W-1:0]    NMinW = N_W'(N_MIN);
  localparam logic [TICK_W-1:0] LoThr = TICK_W'(GATE_MIN_TICKS);
  // Four gates' worth of ticks can exceed 32 bits, so compare in 34.
  localparam logic [TICK_W+1:0] HiThr = ((TICK_W + 2)'(GATE_MIN_TICKS)) << 2;

  logic [N_W:0]   n_dbl;
  logic [N_W-1:0] n_half;

  always_comb begin
    n_dbl  = {n_cur, 1'b0};
    n_half = n_cur >> 1;
    n_next = n_cur;
    if (timeout) begin
      n_next = NMinW;
    end else if (ticks < LoThr) begin
      n_next = (n_dbl > NMaxW) ? NMaxW[N_W-1:0] : n_dbl[N_W-1:0];
    end else if ({2'b00, ticks} > HiThr) begin
      n_next = (n_half < NMinW) ? NMinW : n_half;
    end
  end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Sequencer: round-robins two channels through the period/edge-count core,
// auto-ranges N per channel and hands one result per gate to the host.
module freq_meas_ctrl
  import freq_meas_ctrl_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ   = 50_000_000,
  parameter int unsigned N_MIN          = 1,
  parameter int unsigned N_MAX          = 50_000,
  parameter int unsigned GATE_MIN_TICKS = 20_000_000,
  parameter int unsigned TIMEOUT_CYC    = 75_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              meas_start,
  output logic              meas_abort,
  output logic              meas_ch,
  output logic [N_W-1:0]    meas_n,
  input  logic              meas_done,
  input  logic [TICK_W-1:0] meas_ticks,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_ch,
  output logic [N_W-1:0]    res_n,
  output logic [TICK_W-1:0] res_ticks,
  output logic              res_timeout,
  output logic              busy
);

  if (SYS_CLK_FREQ == 0 || N_MIN == 0 || N_MAX < N_MIN || N_MAX > 32'hFFFF
      || TIMEOUT_CYC == 0) begin : g_bad_params
    $error("freq_meas_ctrl: invalid parameter set");
  end

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                ch_q, ch_d;
  logic [N_W-1:0]      meas_n_q, meas_n_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [TICK_W-1:0]   ticks_q, ticks_d;
  logic                timeout_q, timeout_d;
  logic                res_ch_q, res_ch_d;
  logic [N_W-1:0]      res_n_q, res_n_d;
  logic [TICK_W-1:0]   res_ticks_q, res_ticks_d;
  logic                res_timeout_q, res_timeout_d;
  logic [N_W-1:0]      n_q [NUM_CH];
  logic [N_W-1:0]      n_next;
  logic                n_we;
  logic                timed_out;
  logic                sel_idle, sel_next;

  assign timed_out = (cnt_q == 32'(TIMEOUT_CYC - 1));
  assign sel_idle  = pick_ch(rr_q, ch_mask);
  // On accept the pointer moves past the channel just served.
  assign sel_next  = pick_ch(~ch_q, ch_mask);

  freq_meas_ctrl_autorange #(
    .N_MIN          (N_MIN),
    .N_MAX          (N_MAX),
    .GATE_MIN_TICKS (GATE_MIN_TICKS)
  ) u_autorange (
    .n_cur   (meas_n_q),
    .ticks   (ticks_q),
    .timeout (timeout_q),
    .n_next  (n_next)
  );

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    ch_d          = ch_q;
    meas_n_d      = meas_n_q;
    cnt_d         = cnt_q;
    ticks_d       = ticks_q;
    timeout_d     = timeout_q;
    res_ch_d      = res_ch_q;
    res_n_d       = res_n_q;
    res_ticks_d   = res_ticks_q;
    res_timeout_d = res_timeout_q;
    n_we          = 1'b0;
    meas_start    = 1'b0;
    meas_abort    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run && |ch_mask) begin
          ch_d     = sel_idle;
          meas_n_d = n_q[sel_idle];
          state_d  = StArm;
        end
      end
      StArm: begin
        meas_start = 1'b1;
        cnt_d      = '0;
        state_d    = StWait;
      end
      StWait: begin
        // A completion in the timeout cycle still counts as a real result.
        if (meas_done) begin
          ticks_d   = meas_ticks;
          timeout_d = 1'b0;
          state_d   = StAdj;
        end else if (timed_out) begin
          meas_abort = 1'b1;
          ticks_d    = '0;
          timeout_d  = 1'b1;
          state_d    = StAdj;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StAdj: begin
        n_we          = 1'b1;
        res_ch_d      = ch_q;
        res_n_d       = meas_n_q;
        res_ticks_d   = ticks_q;
        res_timeout_d = timeout_q;
        state_d       = StOut;
      end
      StOut: begin
        if (res_ready) begin
          rr_d = ~ch_q;
          if (run && |ch_mask) begin
            ch_d     = sel_next;
            meas_n_d = n_q[sel_next];
            state_d  = StArm;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StIdle;
      rr_q          <= 1'b0;
      ch_q          <= 1'b0;
      meas_n_q      <= '0;
      cnt_q         <= '0;
      ticks_q       <= '0;
      timeout_q     <= 1'b0;
      res_ch_q      <= 1'b0;
      res_n_q       <= '0;
      res_ticks_q   <= '0;
      res_timeout_q <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) n_q[i] <= N_W'(N_MIN);
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      ch_q          <= ch_d;
      meas_n_q      <= meas_n_d;
      cnt_q         <= cnt_d;
      ticks_q       <= ticks_d;
      timeout_q     <= timeout_d;
      res_ch_q      <= res_ch_d;
      res_n_q       <= res_n_d;
      res_ticks_q   <= res_ticks_d;
      res_timeout_q <= res_timeout_d;
      if (n_we) n_q[ch_q] <= n_next;
    end
  end

  assign meas_ch     = ch_q;
  assign meas_n      = meas_n_q;
  assign res_valid   = (state_q == StOut);
  assign res_ch      = res_ch_q;
  assign res_n       = res_n_q;
  assign res_ticks   = res_ticks_q;
  assign res_timeout = res_timeout_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with small gate/timeout parameters.
module tb_freq_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  ch_mask = 2'b00;
  logic        meas_start, meas_abort, meas_ch;
  logic [15:0] meas_n;
  logic        meas_done = 1'b0;
  logic [31:0] meas_ticks = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_ch;
  logic [15:0] res_n;
  logic [31:0] res_ticks;
  logic        res_timeout, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  freq_meas_ctrl #(
    .N_MIN          (1),
    .N_MAX          (64),
    .GATE_MIN_TICKS (1000),
    .TIMEOUT_CYC    (500)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .run         (run),
    .ch_mask     (ch_mask),
    .meas_start  (meas_start),
    .meas_abort  (meas_abort),
    .meas_ch     (meas_ch),
    .meas_n      (meas_n),
    .meas_done   (meas_done),
    .meas_ticks  (meas_ticks),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ch      (res_ch),
    .res_n       (res_n),
    .res_ticks   (res_ticks),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (meas_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("start_seen", 64'(seen), 64'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // One gate answered 2 cycles after start; optional result stall and run drop.
  task automatic do_gate(input logic [31:0] ticks, input logic exp_ch,
                         input logic [15:0] exp_n, input int stall, input bit drop_run);
    bit seen;
    bit bad;
    wait_start(seen);
    check_eq("meas_ch", 64'(meas_ch), 64'(exp_ch));
    check_eq("meas_n", 64'(meas_n), 64'(exp_n));
    if (drop_run) run = 1'b0;
    repeat (2) @(negedge clk);
    meas_done  = 1'b1;
    meas_ticks = ticks;
    @(negedge clk);
    meas_done = 1'b0;
    check_eq("valid_early", 64'(res_valid), 64'd0);
    @(negedge clk);
    check_eq("res_valid", 64'(res_valid), 64'd1);
    check_eq("res_ch", 64'(res_ch), 64'(exp_ch));
    check_eq("res_n", 64'(res_n), 64'(exp_n));
    check_eq("res_ticks", 64'(res_ticks), 64'(ticks));
    check_eq("res_timeout", 64'(res_timeout), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_n !== exp_n || res_ch !== exp_ch ||
          res_ticks !== ticks || meas_start !== 1'b0) bad = 1'b1;
    end
    if (stall > 0) check_eq("stall_hold", 64'(bad), 64'd0);
    accept();
  endtask

  initial begin
    logic [15:0] ramp_up [8];
    logic [15:0] ramp_dn [8];
    bit seen;
    int k;

    ramp_up = '{16'd1, 16'd2, 16'd4, 16'd8, 16'd16, 16'd32, 16'd64, 16'd64};
    ramp_dn = '{16'd64, 16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd1};

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(res_valid), 64'd0);
    check_eq("rst_meas_n", 64'(meas_n), 64'd0);
    check_eq("rst_start", 64'(meas_start), 64'd0);
    rst_n = 1'b1;

    // Stray completion while idle must be ignored.
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    @(negedge clk);
    check_eq("idle_done_busy", 64'(busy), 64'd0);
    check_eq("idle_done_valid", 64'(res_valid), 64'd0);

    ch_mask = 2'b01;
    run     = 1'b1;
    @(negedge clk);
    foreach (ramp_up[i]) do_gate(32'd100, 1'b0, ramp_up[i], 0, 1'b0);
    foreach (ramp_dn[i]) do_gate(32'd5000, 1'b0, ramp_dn[i], 0, 1'b0);
    do_gate(32'd100, 1'b0, 16'd1, 0, 1'b0);
    do_gate(32'd100, 1'b0, 16'd2, 0, 1'b0);

    // Timeout gate at N=4.
    wait_start(seen);
    check_eq("to_meas_n", 64'(meas_n), 64'd4);
    k = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (meas_abort === 1'b1) begin
        k = i;
        break;
      end
    end
    check_eq("abort_cycle", 64'(k), 64'd500);
    @(negedge clk);
    check_eq("abort_pulse_len", 64'(meas_abort), 64'd0);
    @(negedge clk);
    check_eq("to_valid", 64'(res_valid), 64'd1);
    check_eq("to_flag", 64'(res_timeout), 64'd1);
    check_eq("to_ticks", 64'(res_ticks), 64'd0);
    check_eq("to_res_n", 64'(res_n), 64'd4);
    accept();

    // Completion arrives in the timeout cycle: normal result, no abort.
    wait_start(seen);
    check_eq("race_meas_n", 64'(meas_n), 64'd1);
    repeat (499) @(negedge clk);
    check_eq("abort_not_early", 64'(meas_abort), 64'd0);
    @(negedge clk);
    check_eq("abort_would_fire", 64'(meas_abort), 64'd1);
    meas_done  = 1'b1;
    meas_ticks = 32'd2000;
    #1;
    check_eq("race_no_abort", 64'(meas_abort), 64'd0);
    @(negedge clk);
    meas_done = 1'b0;
    @(negedge clk);
    check_eq("race_valid", 64'(res_valid), 64'd1);
    check_eq("race_timeout", 64'(res_timeout), 64'd0);
    check_eq("race_ticks", 64'(res_ticks), 64'd2000);
    accept();

    do_gate(32'd100, 1'b0, 16'd1, 20, 1'b0);
    do_gate(32'd100, 1'b0, 16'd2, 0, 1'b1);
    @(negedge clk);
    check_eq("drop_busy", 64'(busy), 64'd0);
    k = 0;
    repeat (10) begin
      @(negedge clk);
      if (meas_start === 1'b1) k++;
    end
    check_eq("drop_no_start", 64'(k), 64'd0);

    // Reset in the middle of a gate at N=4.
    run = 1'b1;
    @(negedge clk);
    wait_start(seen);
    check_eq("pre_rst_meas_n", 64'(meas_n), 64'd4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_abort", 64'(meas_abort), 64'd0);
    check_eq("mid_rst_meas_n", 64'(meas_n), 64'd0);
    check_eq("mid_rst_res_n", 64'(res_n), 64'd0);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    ch_mask = 2'b11;
    @(negedge clk);
    do_gate(32'd2000, 1'b0, 16'd1, 0, 1'b0);
    do_gate(32'd2000, 1'b1, 16'd1, 0, 1'b0);
    do_gate(32'd2000, 1'b0, 16'd1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
